// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and helpers for the parametrised register file.
//   rf_state_t : clear-sequencer state (sweeping or idle)
//   rf_addr_w  : address width for a given depth (never below 1 bit)
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;

  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_file_p_clear_seq.sv
// rf_clear_seq: hardware clear sequencer. After reset, or on i_clr while
// idle, it walks every entry from 0 to DEPTH-1 issuing one zero-write per
// cycle.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset (restarts the sweep at entry 0)
//   i_clr      clear request, only honoured while idle
//   o_busy     registered, high for the whole sweep
//   o_clr_we   sweep write strobe for the storage array
//   o_clr_adr  entry being zeroed this cycle
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_adr
);

  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  rf_state_t     r_state;
  rf_state_t     w_state_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_next;
  logic          r_busy;

  // State register. BUSY tracks the next state so it drops on the same edge
  // that writes the last entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next == RF_CLEAR);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      RF_CLEAR: begin
        if (r_cnt == LAST_ADR) begin
          w_state_next = RF_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + AW'(1);
        end
      end
      RF_IDLE: begin
        if (i_clr) begin
          w_state_next = RF_CLEAR;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = RF_CLEAR;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_clr_we  = (r_state == RF_CLEAR);
    o_clr_adr = r_cnt;
    o_busy    = r_busy;
  end

endmodule

// File: rtl/reg_file_p.sv
// reg_file_p: DEPTH x WIDTH register file with one write port, NUM_RD
// asynchronous read ports, optional write-first bypass and a hardware
// clear sweep after reset or on request.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_wr_en    write enable
//   i_wr_adr   write address
//   i_din      write data
//   i_clr      full-clear request (ignored while a sweep runs)
//   i_rd_adr   packed read addresses, port k at [k*AW +: AW]
//   o_rd_data  packed read data, port k at [k*WIDTH +: WIDTH]
//   o_busy     clear sweep in progress
//   o_wr_drop  a requested write is being discarded this cycle
module reg_file_p
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 32,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = rf_addr_w(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_adr,
  input  logic [WIDTH-1:0]        i_din,
  input  logic                    i_clr,
  input  logic [NUM_RD*AW-1:0]    i_rd_adr,
  output logic [NUM_RD*WIDTH-1:0] o_rd_data,
  output logic                    o_busy,
  output logic                    o_wr_drop
);

  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_adr;
  logic             w_wr_adr_ok;
  logic             w_wr_acc;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_adr;
  logic [WIDTH-1:0] w_mem_din;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_adr (w_clr_adr)
  );

  // A user write lands only when idle, not colliding with a clear request,
  // and addressed inside the array.
  assign w_wr_adr_ok = ({1'b0, i_wr_adr} < DEPTH_W);
  assign w_wr_acc    = i_wr_en & ~w_busy & ~i_clr & w_wr_adr_ok;
  assign o_wr_drop   = i_wr_en & ~w_wr_acc;
  assign o_busy      = w_busy;

  // Sweep and user writes never overlap: user writes need BUSY low.
  assign w_mem_we  = w_clr_we | w_wr_acc;
  assign w_mem_adr = w_clr_we ? w_clr_adr : i_wr_adr;
  assign w_mem_din = w_clr_we ? '0 : i_din;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_adr] <= w_mem_din;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] w_rd_adr;
    logic          w_rd_ok;
    logic          w_rd_hit;

    assign w_rd_adr = i_rd_adr[gi*AW +: AW];
    assign w_rd_ok  = ({1'b0, w_rd_adr} < DEPTH_W);
    assign w_rd_hit = (BYPASS != 0) && w_wr_acc && (i_wr_adr == w_rd_adr);

    assign o_rd_data[gi*WIDTH +: WIDTH] =
      (w_busy || !w_rd_ok) ? '0 :
      w_rd_hit             ? i_din :
                             r_mem[w_rd_adr];
  end

endmodule

// File: tb/tb_reg_file_p.sv
module tb_reg_file_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_adr;
  logic [7:0] din;
  logic       clr;
  logic [9:0] rd_adr;

  logic [15:0] rd_data_w [3];
  logic        busy_w    [3];
  logic        drop_w    [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: 32 deep bypass, 1: 32 deep no bypass, 2: 20 deep bypass
  reg_file_p #(.WIDTH(8), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_adr(wr_adr),
    .i_din(din), .i_clr(clr), .i_rd_adr(rd_adr),
    .o_rd_data(rd_data_w[0]), .o_busy(busy_w[0]), .o_wr_drop(drop_w[0]));

  reg_file_p #(.WIDTH(8), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_adr(wr_adr),
    .i_din(din), .i_clr(clr), .i_rd_adr(rd_adr),
    .o_rd_data(rd_data_w[1]), .o_busy(busy_w[1]), .o_wr_drop(drop_w[1]));

  reg_file_p #(.WIDTH(8), .DEPTH(20), .NUM_RD(2), .BYPASS(1)) u_dut_d20 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_adr(wr_adr),
    .i_din(din), .i_clr(clr), .i_rd_adr(rd_adr),
    .o_rd_data(rd_data_w[2]), .o_busy(busy_w[2]), .o_wr_drop(drop_w[2]));

  // Reference model: contents plus a countdown of sweep cycles remaining.
  int         mdepth [3] = '{32, 32, 20};
  int         mbyp   [3] = '{1, 0, 1};
  logic [7:0] mmem   [3][32];
  int         mleft  [3];

  function automatic bit m_acc(int m);
    return rst_n && wr_en && (mleft[m] == 0) && !clr && (int'(wr_adr) < mdepth[m]);
  endfunction

  function automatic logic [7:0] m_rd(int m, logic [4:0] a);
    if (mleft[m] > 0) return 8'h00;
    if (int'(a) >= mdepth[m]) return 8'h00;
    if (mbyp[m] == 1 && m_acc(m) && wr_adr == a) return din;
    return mmem[m][a];
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 3; m++) begin
      if (!rst_n) begin
        mleft[m] = mdepth[m];
      end else if (mleft[m] > 0) begin
        mmem[m][mdepth[m] - mleft[m]] = 8'h00;
        mleft[m]--;
      end else if (clr) begin
        mleft[m] = mdepth[m];
      end else if (m_acc(m)) begin
        mmem[m][wr_adr] = din;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) mleft[m] = mdepth[m];
  endtask

  // Counts edges until each DUT's BUSY falls (bounded). Optionally drives
  // a write each cycle and tallies WR_DROP disagreements with the model.
  task automatic measure_sweep(input int pulse_at, input bit drive_wr,
                               output int f0, output int f1, output int f2,
                               output int bad_drop);
    int f [3];
    f = '{-1, -1, -1};
    bad_drop = 0;
    for (int k = 1; k <= 100; k++) begin
      if (drive_wr) begin
        wr_en = 1'b1; wr_adr = 5'd3; din = 8'hAA;
        #1;
        for (int m = 0; m < 3; m++)
          if (drop_w[m] !== (wr_en && !m_acc(m))) bad_drop++;
        wr_en = 1'b0;
      end
      clr = (k == pulse_at);
      tick();
      clr = 1'b0;
      for (int m = 0; m < 3; m++)
        if (f[m] < 0 && busy_w[m] === 1'b0) f[m] = k;
      if (f[0] >= 0 && f[1] >= 0 && f[2] >= 0) break;
    end
    f0 = f[0]; f1 = f[1]; f2 = f[2];
  endtask

  task automatic test_reset();
    int f0, f1, f2, bad;
    rst_n = 1'b0; wr_en = 1'b1; wr_adr = 5'd3; din = 8'hAA; clr = 1'b0; rd_adr = '0;
    model_reset();
    tick(); tick();
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (busy_w[m] !== 1'b1) begin n_fail++; $display("FAIL rst_busy dut%0d got %b want 1", m, busy_w[m]); end
      n_tests++;
      if (rd_data_w[m] !== 16'h0000) begin n_fail++; $display("FAIL rst_rd dut%0d got %h want 0000", m, rd_data_w[m]); end
      n_tests++;
      if (drop_w[m] !== 1'b1) begin n_fail++; $display("FAIL rst_drop dut%0d got %b want 1", m, drop_w[m]); end
    end
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (drop_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_drop_noreq got %b want 0", drop_w[0]); end
    rst_n = 1'b1;
    $display("[TB] reset released, sweeping with writes to addr 3");
    measure_sweep(0, 1'b1, f0, f1, f2, bad);
    n_tests++;
    if (f0 != 32) begin n_fail++; $display("FAIL sweep_len_b got %0d want 32", f0); end
    n_tests++;
    if (f1 != 32) begin n_fail++; $display("FAIL sweep_len_nb got %0d want 32", f1); end
    n_tests++;
    if (f2 != 20) begin n_fail++; $display("FAIL sweep_len_d20 got %0d want 20", f2); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL sweep_wr_drop got %0d bad cycles want 0", bad); end
    rd_adr = {5'd3, 5'd3};
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (rd_data_w[m] !== 16'h0000) begin n_fail++; $display("FAIL post_sweep_rd3 dut%0d got %h want 0000", m, rd_data_w[m]); end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_adr = 5'd7; din = 8'h5C;
    $display("[TB] write addr 7 data 5c");
    tick();
    wr_en = 1'b0; rd_adr = {5'd7, 5'd7};
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (rd_data_w[m] !== 16'h5C5C) begin n_fail++; $display("FAIL rd7_both dut%0d got %h want 5c5c", m, rd_data_w[m]); end
    end
    rd_adr = {5'd8, 5'd8};
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (rd_data_w[m] !== 16'h0000) begin n_fail++; $display("FAIL rd8 dut%0d got %h want 0000", m, rd_data_w[m]); end
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_adr = 5'd12; din = 8'h3E; rd_adr = {5'd0, 5'd12};
    $display("[TB] write addr 12 data 3e with same-cycle read");
    #1;
    n_tests++;
    if (rd_data_w[0][7:0] !== 8'h3E) begin n_fail++; $display("FAIL bypass_on got %h want 3e", rd_data_w[0][7:0]); end
    n_tests++;
    if (rd_data_w[1][7:0] !== 8'h00) begin n_fail++; $display("FAIL bypass_off_same got %h want 00", rd_data_w[1][7:0]); end
    n_tests++;
    if (rd_data_w[2][7:0] !== 8'h3E) begin n_fail++; $display("FAIL bypass_on_d20 got %h want 3e", rd_data_w[2][7:0]); end
    tick();
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (rd_data_w[1][7:0] !== 8'h3E) begin n_fail++; $display("FAIL bypass_off_next got %h want 3e", rd_data_w[1][7:0]); end
  endtask

  task automatic test_clr_collision();
    int f0, f1, f2, bad;
    clr = 1'b1; wr_en = 1'b1; wr_adr = 5'd5; din = 8'h11;
    $display("[TB] clear with simultaneous write addr 5 data 11");
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (drop_w[m] !== 1'b1) begin n_fail++; $display("FAIL clr_wr_drop dut%0d got %b want 1", m, drop_w[m]); end
    end
    tick();
    clr = 1'b0; wr_en = 1'b0;
    measure_sweep(10, 1'b0, f0, f1, f2, bad);
    n_tests++;
    if (f0 != 32) begin n_fail++; $display("FAIL clr_sweep_len got %0d want 32", f0); end
    n_tests++;
    if (f2 != 20) begin n_fail++; $display("FAIL clr_sweep_len_d20 got %0d want 20", f2); end
    rd_adr = {5'd7, 5'd5};
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (rd_data_w[m] !== 16'h0000) begin n_fail++; $display("FAIL clr_rd_5_7 dut%0d got %h want 0000", m, rd_data_w[m]); end
    end
  endtask

  task automatic test_depth20();
    wr_en = 1'b1; wr_adr = 5'd25; din = 8'h77;
    $display("[TB] write addr 25 data 77");
    #1;
    n_tests++;
    if (drop_w[2] !== 1'b1) begin n_fail++; $display("FAIL d20_oor_drop got %b want 1", drop_w[2]); end
    n_tests++;
    if (drop_w[0] !== 1'b0) begin n_fail++; $display("FAIL d32_inrange_drop got %b want 0", drop_w[0]); end
    tick();
    wr_en = 1'b0; rd_adr = {5'd0, 5'd25};
    #1;
    n_tests++;
    if (rd_data_w[2][7:0] !== 8'h00) begin n_fail++; $display("FAIL d20_rd25 got %h want 00", rd_data_w[2][7:0]); end
    n_tests++;
    if (rd_data_w[0][7:0] !== 8'h77) begin n_fail++; $display("FAIL d32_rd25 got %h want 77", rd_data_w[0][7:0]); end
    wr_en = 1'b1; wr_adr = 5'd19; din = 8'h42;
    $display("[TB] write addr 19 data 42");
    tick();
    wr_en = 1'b0; rd_adr = {5'd19, 5'd0};
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (rd_data_w[m][15:8] !== 8'h42) begin n_fail++; $display("FAIL rd19 dut%0d got %h want 42", m, rd_data_w[m][15:8]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int f0, f1, f2, bad;
    clr = 1'b1;
    $display("[TB] clear then reset at sweep cycle 10");
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rd_adr = {5'd19, 5'd25};
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (rd_data_w[m] !== 16'h0000) begin n_fail++; $display("FAIL midrst_rd dut%0d got %h want 0000", m, rd_data_w[m]); end
      n_tests++;
      if (busy_w[m] !== 1'b1) begin n_fail++; $display("FAIL midrst_busy dut%0d got %b want 1", m, busy_w[m]); end
    end
    tick(); tick();
    rst_n = 1'b1;
    measure_sweep(0, 1'b0, f0, f1, f2, bad);
    n_tests++;
    if (f0 != 32) begin n_fail++; $display("FAIL midrst_sweep_len got %0d want 32", f0); end
    n_tests++;
    if (f2 != 20) begin n_fail++; $display("FAIL midrst_sweep_len_d20 got %0d want 20", f2); end
  endtask

  task automatic test_random();
    logic [4:0] a0, a1;
    logic [7:0] e0, e1;
    for (int c = 0; c < 400; c++) begin
      wr_en  = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 59) == 0);
      wr_adr = 5'($urandom_range(0, 31));
      din    = 8'($urandom);
      a0     = 5'($urandom_range(0, 31));
      a1     = ($urandom_range(0, 2) == 0) ? wr_adr : 5'($urandom_range(0, 31));
      rd_adr = {a1, a0};
      #1;
      if (clr || wr_en)
        $display("[TB] rnd cyc %0d wr_en %0d clr %0d adr %0d din %h", c, wr_en, clr, wr_adr, din);
      for (int m = 0; m < 3; m++) begin
        e0 = m_rd(m, a0);
        e1 = m_rd(m, a1);
        n_tests++;
        if (rd_data_w[m][7:0] !== e0) begin n_fail++; $display("FAIL rnd_rd0 dut%0d cyc %0d got %h want %h", m, c, rd_data_w[m][7:0], e0); end
        n_tests++;
        if (rd_data_w[m][15:8] !== e1) begin n_fail++; $display("FAIL rnd_rd1 dut%0d cyc %0d got %h want %h", m, c, rd_data_w[m][15:8], e1); end
        n_tests++;
        if (busy_w[m] !== (mleft[m] > 0)) begin n_fail++; $display("FAIL rnd_busy dut%0d cyc %0d got %b want %b", m, c, busy_w[m], (mleft[m] > 0)); end
        n_tests++;
        if (drop_w[m] !== (wr_en && !m_acc(m))) begin n_fail++; $display("FAIL rnd_drop dut%0d cyc %0d got %b want %b", m, c, drop_w[m], (wr_en && !m_acc(m))); end
      end
      tick();
    end
    wr_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 32; i++) mmem[m][i] = 8'h00;
    test_reset();
    test_write_read();
    test_bypass();
    test_clr_collision();
    test_depth20();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
